// File: rtl/instr_mem_sync.sv
// instr_mem_sync: word-addressed instruction memory with a boot load port and a registered fetch port.
// Define IMEM_PARITY_EN to store an even-parity bit per word and fault fetches whose parity mismatches.
module instr_mem_sync #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = 'h13
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_valid,
    input  logic [DATA_W-1:0]            load_data,
    input  logic                         load_last,
    output logic                         load_ready,
    output logic [$clog2(DEPTH+1)-1:0]   load_count,
    output logic                         running,
    input  logic                         fetch_req,
    input  logic [ADDR_W-1:0]            fetch_addr,
    input  logic                         fetch_stall,
    output logic                         fetch_valid,
    output logic [DATA_W-1:0]            fetch_data,
    output logic                         fetch_fault
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-3:0] DEPTH_IDX = (ADDR_W-2)'(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    typedef enum logic {LOAD, RUN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                fault_q, fault_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [MEM_W-1:0]    mem [DEPTH];
    logic [MEM_W-1:0]    wr_entry, rd_entry;
    logic                mem_we, accept, fault;
    logic [ADDR_W-3:0]   idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            data_q  <= data_d;
        end
    end

    // Contents survive reset; only the write is gated by it.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we)
            mem[cnt_q[PTR_W-1:0]] <= wr_entry;
    end

    always_comb begin
        mem_we  = state_q == LOAD && load_valid;
        state_d = (mem_we && (load_last || cnt_q == CNT_W'(DEPTH-1))) ? RUN : state_q;
        cnt_d   = mem_we ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
`ifdef IMEM_PARITY_EN
        wr_entry = {^load_data, load_data};
`else
        wr_entry = load_data;
`endif
        idx      = fetch_addr[ADDR_W-1:2];
        rd_entry = mem[idx[PTR_W-1:0]];
`ifdef IMEM_PARITY_EN
        fault    = |fetch_addr[1:0] || idx >= DEPTH_IDX || ^rd_entry;
`else
        fault    = |fetch_addr[1:0] || idx >= DEPTH_IDX;
`endif
        accept   = state_q == RUN && !fetch_stall;
        valid_d  = accept ? fetch_req : valid_q;
        fault_d  = accept ? fetch_req && fault : fault_q;
        data_d   = (accept && fetch_req) ? (fault ? NOP_WORD : rd_entry[DATA_W-1:0]) : data_q;
    end

    always_comb begin
        load_ready = state_q == LOAD;
        running    = state_q == RUN;
    end

    assign load_count  = cnt_q;
    assign fetch_valid = valid_q;
    assign fetch_data  = data_q;
    assign fetch_fault = fault_q;
endmodule

// File: tb/tb_instr_mem_sync.sv
// tb_instr_mem_sync: directed load/fetch/stall/fault/reset vectors for instr_mem_sync at default parameters.
module tb_instr_mem_sync;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic              clk = 1'b0;
    logic              rst_n, load_valid, load_last, load_ready, running;
    logic              fetch_req, fetch_stall, fetch_valid, fetch_fault;
    logic [DATA_W-1:0] load_data, fetch_data;
    logic [ADDR_W-1:0] fetch_addr;
    logic [10:0]       load_count;
    logic [31:0]       prog [4] = '{32'h0062E233, 32'h00832383, 32'h0064A423, 32'hFFC4A303};
    int                n_chk = 0, n_pass = 0;

    instr_mem_sync dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .load_count(load_count), .running(running),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_stall(fetch_stall),
        .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] addr);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_last = 1'b0; load_data = '0;
        fetch_req = 1'b0; fetch_addr = '0; fetch_stall = 1'b0;
        step();
        do_reset();
        chk("rst_load_ready", load_ready, 1);
        chk("rst_running", running, 0);
        chk("rst_valid", fetch_valid, 0);
        chk("rst_data", fetch_data, 0);
        chk("rst_fault", fetch_fault, 0);
        chk("rst_count", load_count, 0);

        fetch(32'h0);
        chk("load_fetch_ignored", fetch_valid, 0);

        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1; load_data = prog[i]; load_last = (i == 3);
            step();
            if (i < 3) chk("load_not_running", running, 0);
        end
        load_valid = 1'b0; load_last = 1'b0;
        chk("load4_count", load_count, 4);
        chk("load4_running", running, 1);
        chk("load4_ready", load_ready, 0);

        fetch_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fetch_addr = 32'(4 * i);
            step();
            chk("b2b_valid", fetch_valid, 1);
            chk("b2b_data", fetch_data, prog[i]);
            chk("b2b_fault", fetch_fault, 0);
        end
        fetch_req = 1'b0;
        step();
        chk("idle_valid", fetch_valid, 0);
        chk("idle_fault", fetch_fault, 0);
        chk("idle_data_held", fetch_data, prog[3]);

        fetch(32'h2);
        chk("misalign_valid", fetch_valid, 1);
        chk("misalign_fault", fetch_fault, 1);
        chk("misalign_data", fetch_data, NOP);
        fetch(32'h1000);
        chk("range_fault", fetch_fault, 1);
        chk("range_data", fetch_data, NOP);

        fetch(32'h4);
        chk("pre_stall_data", fetch_data, prog[1]);
        fetch_stall = 1'b1; fetch_req = 1'b1; fetch_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", fetch_valid, 1);
            chk("stall_data", fetch_data, prog[1]);
            chk("stall_fault", fetch_fault, 0);
        end
        fetch_stall = 1'b0;
        step();
        fetch_req = 1'b0;
        chk("unstall_data", fetch_data, prog[2]);
        chk("unstall_valid", fetch_valid, 1);

        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1; load_data = 32'hA000_0000 + 32'(i);
            step();
            if (i == DEPTH - 2) chk("full_not_yet_running", running, 0);
        end
        chk("full_running", running, 1);
        chk("full_count", load_count, DEPTH);
        load_data = 32'hDEAD_BEEF;
        step();
        load_valid = 1'b0;
        chk("extra_count", load_count, DEPTH);
        fetch(32'h0);
        chk("extra_word0", fetch_data, 32'hA000_0000);
        fetch(32'hFFC);
        chk("last_word", fetch_data, 32'hA000_03FF);
        chk("last_word_fault", fetch_fault, 0);

        do_reset();
        for (int i = 0; i < 2; i++) begin
            load_valid = 1'b1; load_data = 32'h1111_1111 * (i + 1);
            step();
        end
        chk("mid_count", load_count, 2);
        rst_n = 1'b0; load_data = 32'h3333_3333; fetch_req = 1'b1;
        step();
        rst_n = 1'b1; load_valid = 1'b0; fetch_req = 1'b0;
        chk("midrst_count", load_count, 0);
        chk("midrst_data", fetch_data, 0);
        chk("midrst_valid", fetch_valid, 0);
        chk("midrst_ready", load_ready, 1);
        chk("midrst_running", running, 0);
        load_valid = 1'b1; load_last = 1'b1; load_data = 32'h5555_5555;
        step();
        load_valid = 1'b0; load_last = 1'b0;
        chk("reload_count", load_count, 1);
        chk("reload_running", running, 1);
        fetch(32'h0);
        chk("reload_word0", fetch_data, 32'h5555_5555);
        fetch(32'h4);
        chk("kept_word1", fetch_data, 32'h2222_2222);
        fetch(32'h8);
        chk("rst_blocked_write", fetch_data, 32'hA000_0002);

`ifdef IMEM_PARITY_EN
        dut.mem[1][DATA_W] = ~dut.mem[1][DATA_W];
        fetch(32'h4);
        chk("parity_fault", fetch_fault, 1);
        chk("parity_data", fetch_data, NOP);
        fetch(32'h0);
        chk("parity_ok_fault", fetch_fault, 0);
        chk("parity_ok_data", fetch_data, 32'h5555_5555);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
- Parametrised, word-addressed instruction memory with a registered (1-cycle) read port. Replaces the combinational ROM in the fetch stage.
- Adds a boot-time load port that streams the program in through an auto-incrementing write pointer.
- Adds a fetch handshake with stall hold and a fault flag for misaligned or out-of-range fetches.
- Sits between the PC register and the decode stage.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 1024, number of words; any value ≥ 2, not required to be a power of two.
- ADDR_W, 32, byte-address width of fetch_addr.
- NOP_WORD, 32'h00000013, word returned on a fault (RISC-V addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- load_valid  in  1  load word present.
- load_data  in  DATA_W  word to write at the load pointer.
- load_last  in  1  final word of the program; sampled with load_valid.
- load_ready  out  1  high while in LOAD state.
- load_count  out  $clog2(DEPTH+1)  number of words written since reset.
- running  out  1  high in RUN state.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address of the fetch.
- fetch_stall  in  1  downstream stall; fetch outputs are held.
- fetch_valid  out  1  fetch_data is valid.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_fault  out  1  the fetch was misaligned or out of range.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state becomes LOAD; load pointer and load_count become 0.
  - fetch_valid=0, fetch_data=0, fetch_fault=0, running=0, load_ready=1 from the next cycle.
  - Memory contents are not cleared.
  - Reset overrides every other input in the same cycle, including mid-load or mid-fetch.
- States: LOAD and RUN. RUN is left only through reset.
- LOAD:
  - load_ready=1.
  - Each edge with load_valid=1 writes mem[ptr]=load_data, then ptr and load_count increment.
  - Go to RUN after the write when load_last=1, or when the word written was at ptr=DEPTH-1.
  - Words offered after that point are not written.
  - fetch_req is ignored and fetch_valid stays 0.
- RUN:
  - load_ready=0; load_valid is ignored.
  - Word index = fetch_addr[ADDR_W-1:2].
  - Fault when fetch_addr[1:0]!=0 or index ≥ DEPTH.
- Fetch timing, RUN only, fetch_stall=0:
  - fetch_req=1 at edge N gives fetch_valid=1 at edge N+1.
  - fetch_data = mem[index], or NOP_WORD if faulted.
  - fetch_fault = fault condition.
  - fetch_req=0 gives fetch_valid=0 at N+1, with fetch_fault=0 and fetch_data unchanged.
- Stall: fetch_stall=1 holds fetch_valid, fetch_data and fetch_fault unchanged. A fetch_req in that cycle is dropped; the PC holds, so the requester re-presents it.
- Back-to-back fetches sustain one word per cycle with no bubbles.
- Reading an address never written since reset returns stale or X contents. Fault is not flagged for this case.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed on load.
  - A fetch whose stored parity mismatches asserts fetch_fault and returns NOP_WORD, with the same timing and stall rules as other faults.
- Undefined: no parity storage, and fetch_fault covers only misalignment and range.

Test Plan:
- Reset then load 4 words (0x0062E233, 0x00832383, 0x0064A423, 0xFFC4A303) with load_last on the 4th:
  - load_count=4, running=1 the cycle after the 4th write, load_ready=0.
  - Fetch 0x0,0x4,0x8,0xC back-to-back → fetch_data equals the loaded words in order, each 1 cycle after its request, fetch_valid continuous.
- Fetch 0x2 → fetch_fault=1, fetch_data=0x00000013. Fetch 4*DEPTH (0x1000 at DEPTH=1024) → the same result.
- Fetch 0x4 then fetch_stall=1 for 3 cycles with fetch_req=1, addr 0x8 → outputs hold 0x00832383 for all 3 cycles. Release the stall → 0x0064A423 on the next edge after the re-request.
- In LOAD, fetch_req=1 → fetch_valid stays 0. Load DEPTH words without load_last → running=1 after word DEPTH-1; an extra load_valid does not change word 0.
- rst_n low mid-load after 2 words:
  - load_count=0, fetch_data=0, fetch_valid=0, state LOAD.
  - Reload 1 word with load_last, fetch 0x0 → the new word.
- With IMEM_PARITY_EN: force a parity bit flip on word 1 via hierarchical write, fetch 0x4 → fetch_fault=1, data 0x00000013. Word 0 still reads correctly.
